// File: rtl/sie_defs_pkg.sv
// rtl/sie_defs_pkg.sv - shared SIE receive definitions: states, line levels, SYNC and CRC residuals, PIDs
package sie_defs_pkg;

  typedef enum logic [1:0] {
    RX_WAIT_SYNC,
    RX_DATA,
    RX_EOP,
    RX_ERROR
  } RxStates;

  // Line levels as {D+, D-}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0]  SYNC_DECODED   = 8'h80;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110,
    PID_PRE   = 4'b1100
  } PID_Types;

  function automatic logic pid_check_bad(input logic [7:0] pid);
    return pid[7:4] != ~pid[3:0];
  endfunction

endpackage

// File: rtl/nrzi_decoder.sv
// rtl/nrzi_decoder.sv - NRZI decode of one line sample per bit time, with SE0/SE1 detection
module nrzi_decoder
  import sie_defs_pkg::*;
(
  input  logic       clk12,
  input  logic       RST,
  input  logic [1:0] line_state,
  input  logic       reload,
  output logic       nrzi_bit,
  output logic       se0
);

  logic prev_j;
  logic is_j;
  logic is_k;

  always_comb begin
    is_j     = (line_state == LINE_J);
    is_k     = (line_state == LINE_K);
    se0      = !(is_j || is_k) || (line_state == LINE_SE0);
    nrzi_bit = !se0 && (is_j == prev_j);
  end

  // SE0 (and SE1) leave the reference at J, which is where the line returns to
  always_ff @(posedge clk12) begin
    if (RST || reload || se0) prev_j <= 1'b1;
    else                      prev_j <= is_j;
  end

endmodule

// File: rtl/usb_crc.sv
// rtl/usb_crc.sv - serial CRC5/CRC16 residual checker over LSB-first unstuffed bits
module usb_crc
  import sie_defs_pkg::*;
(
  input  logic clk12,
  input  logic RST,
  input  logic init,
  input  logic shift,
  input  logic data_bit,
  input  logic use_crc16,
  output logic validCRC
);

  logic [15:0] crc16;
  logic [4:0]  crc5;

  always_ff @(posedge clk12) begin
    if (RST || init) begin
      crc16 <= 16'hFFFF;
      crc5  <= 5'h1F;
    end else if (shift) begin
      crc16 <= {crc16[14:0], 1'b0} ^ ((data_bit ^ crc16[15]) ? 16'h8005 : 16'h0000);
      crc5  <= {crc5[3:0], 1'b0} ^ ((data_bit ^ crc5[4]) ? 5'h05 : 5'h00);
    end
  end

  assign validCRC = use_crc16 ? (crc16 == CRC16_RESIDUAL) : (crc5 == CRC5_RESIDUAL);

endmodule

// File: rtl/usb_rx.sv
// rtl/usb_rx.sv - full-speed USB receive path: SYNC/EOP detect, unstuff, deserialize, byte handshake
// CRC5/CRC16 checking is built only when USB_RX_CRC_CHECK_EN is defined.
module usb_rx
  import sie_defs_pkg::*;
(
  input  logic       clk12,
  input  logic       RST,
  input  logic       dataInP,
  input  logic       dataInN,
  input  logic       rxAcceptNewData,
  output logic [7:0] rxData,
  output logic       rxDataValid,
  output logic       rxIsLastByte,
  output logic       rxPIDError,
  output logic       rxCRCError,
  output logic       rxFrameError,
  output logic       receiving
);

  RxStates    state;
  logic [7:0] window;
  logic [7:0] shreg;
  logic [7:0] pend_data;
  logic [7:0] pid;
  logic       pend_valid;
  logic       pid_done;
  logic [2:0] bit_cnt;
  logic [2:0] ones_cnt;
  logic       se0_seen;

  logic       nrzi_bit;
  logic       se0;
  logic       line_j;
  logic [7:0] win_next;
  logic [7:0] byte_next;
  logic       stuff_slot;
  logic       byte_done;
  logic       promote_last;
  logic       promote;
  logic       out_free;
  logic       pid_bad;
  logic       crc_bad;
  logic       to_idle;

  assign line_j = ({dataInP, dataInN} == LINE_J);

  nrzi_decoder u_nrzi (
    .clk12      (clk12),
    .RST        (RST),
    .line_state ({dataInP, dataInN}),
    .reload     (to_idle),
    .nrzi_bit   (nrzi_bit),
    .se0        (se0)
  );

  always_comb begin
    win_next     = {nrzi_bit, window[7:1]};
    byte_next    = {nrzi_bit, shreg[7:1]};
    stuff_slot   = (ones_cnt == 3'd6);
    byte_done    = (state == RX_DATA) && !se0 && !stuff_slot && (bit_cnt == 3'd7);
    promote_last = (state == RX_DATA) && se0 && (bit_cnt == 3'd0);
    promote      = pend_valid && (byte_done || promote_last);
    out_free     = !rxDataValid || rxAcceptNewData;
    pid_bad      = pid_check_bad(pid);
    to_idle      = ((state == RX_EOP) || (state == RX_ERROR)) && se0_seen && line_j;
  end

`ifdef USB_RX_CRC_CHECK_EN
  logic crc_valid;
  logic crc_shift;

  // Only bits after the PID feed the CRC; stuffed bits never do
  assign crc_shift = (state == RX_DATA) && !se0 && !stuff_slot && pid_done;

  usb_crc u_crc (
    .clk12     (clk12),
    .RST       (RST),
    .init      (state == RX_WAIT_SYNC),
    .shift     (crc_shift),
    .data_bit  (nrzi_bit),
    .use_crc16 (pid[1:0] == 2'b11),
    .validCRC  (crc_valid)
  );

  assign crc_bad = pid[0] && !crc_valid;
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clk12) begin
    if (RST) begin
      state        <= RX_WAIT_SYNC;
      window       <= 8'hFF;
      shreg        <= 8'h00;
      pend_data    <= 8'h00;
      pid          <= 8'h00;
      pend_valid   <= 1'b0;
      pid_done     <= 1'b0;
      bit_cnt      <= 3'd0;
      ones_cnt     <= 3'd0;
      se0_seen     <= 1'b0;
      rxData       <= 8'h00;
      rxDataValid  <= 1'b0;
      rxIsLastByte <= 1'b0;
      rxPIDError   <= 1'b0;
      rxCRCError   <= 1'b0;
      rxFrameError <= 1'b0;
      receiving    <= 1'b0;
    end else begin
      if (rxDataValid && rxAcceptNewData) rxDataValid <= 1'b0;

      // The held output byte is never overwritten; a blocked promotion is an overflow
      if (promote) begin
        if (out_free) begin
          rxData       <= pend_data;
          rxDataValid  <= 1'b1;
          rxIsLastByte <= promote_last;
          rxPIDError   <= promote_last && pid_bad;
          rxCRCError   <= promote_last && crc_bad;
        end else begin
          rxFrameError <= 1'b1;
        end
      end

      unique case (state)
        RX_WAIT_SYNC: begin
          if (se0) begin
            window <= 8'hFF;
          end else if (win_next == SYNC_DECODED) begin
            state        <= RX_DATA;
            receiving    <= 1'b1;
            rxFrameError <= 1'b0;
            window       <= 8'hFF;
            bit_cnt      <= 3'd0;
            ones_cnt     <= 3'd0;
            pend_valid   <= 1'b0;
            pid_done     <= 1'b0;
          end else begin
            window <= win_next;
          end
        end

        RX_DATA: begin
          if (se0) begin
            pend_valid <= 1'b0;
            if (bit_cnt != 3'd0) begin
              rxFrameError <= 1'b1;
              state        <= RX_ERROR;
              se0_seen     <= 1'b1;
            end else begin
              state    <= RX_EOP;
              se0_seen <= 1'b0;
            end
          end else if (stuff_slot) begin
            ones_cnt <= 3'd0;
            if (nrzi_bit) begin
              rxFrameError <= 1'b1;
              pend_valid   <= 1'b0;
              state        <= RX_ERROR;
              se0_seen     <= 1'b0;
            end
          end else begin
            shreg    <= byte_next;
            bit_cnt  <= bit_cnt + 3'd1;
            ones_cnt <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
            if (byte_done) begin
              pend_data  <= byte_next;
              pend_valid <= 1'b1;
              pid_done   <= 1'b1;
              if (!pid_done) pid <= byte_next;
            end
          end
        end

        RX_EOP: begin
          if (!se0_seen && se0) begin
            se0_seen <= 1'b1;
          end else if (to_idle) begin
            state     <= RX_WAIT_SYNC;
            receiving <= 1'b0;
            se0_seen  <= 1'b0;
          end else begin
            state        <= RX_ERROR;
            rxFrameError <= 1'b1;
            se0_seen     <= se0;
          end
        end

        RX_ERROR: begin
          rxFrameError <= 1'b1;
          if (se0) begin
            se0_seen <= 1'b1;
          end else if (to_idle) begin
            state     <= RX_WAIT_SYNC;
            receiving <= 1'b0;
            se0_seen  <= 1'b0;
          end else begin
            se0_seen <= 1'b0;
          end
        end

        default: state <= RX_WAIT_SYNC;
      endcase
    end
  end

endmodule

// File: doc/usb_rx.md
# usb_rx

Full-speed USB receive path of the SIE, the receiving counterpart of the transmit serializer. It takes one synchronized differential line sample per bit time, NRZI-decodes it, removes stuffed bits, detects SYNC and EOP, and deserializes the packet into bytes (PID first). Bytes are delivered on a valid/accept handshake with last-byte, PID, CRC and framing status. It sits between the line sampler/clock recovery and the packet-level SIE logic.

## Interface
Parameters: none.

Ports:
- clk12  in  1  bit clock; one line sample per cycle
- RST  in  1  reset, synchronous, active-high
- dataInP  in  1  synchronized D+ sample
- dataInN  in  1  synchronized D- sample
- rxAcceptNewData  in  1  consumer ready; transfer when rxDataValid && rxAcceptNewData
- rxData  out  8  received byte; first byte is the PID
- rxDataValid  out  1  rxData holds an untransferred byte
- rxIsLastByte  out  1  qualifies rxData as the final byte before EOP
- rxPIDError  out  1  PID check nibble mismatch; qualified by rxIsLastByte
- rxCRCError  out  1  CRC residual wrong; qualified by rxIsLastByte
- rxFrameError  out  1  bit-stuff violation, SE0 off a byte boundary, or overflow; sticky until next SYNC
- receiving  out  1  high from SYNC match to end of EOP

## Operation
- Line states: J = (P=1, N=0), K = (0,1), SE0 = (0,0), SE1 = (1,1), which is treated as SE0.
- NRZI: decoded bit is 1 if the sample equals the previous sample, else 0. The previous-sample register resets to J and is reloaded with J in RX_WAIT_SYNC.
- States:
  - RX_WAIT_SYNC: shift decoded bits into an 8-bit window, LSB-first. When the window equals 8'h80, go to RX_DATA on the next cycle.
  - RX_DATA: unstuff, count bits, assemble bytes. SE0 moves to RX_EOP.
  - RX_EOP: expects one more SE0, then J, then RX_WAIT_SYNC. Any other sequence moves to RX_ERROR.
  - RX_ERROR: sets rxFrameError and waits for SE0 followed by J, then RX_WAIT_SYNC.
- Unstuffing: after six consecutive decoded 1s, the next bit is dropped. If that bit is 1, set rxFrameError and go to RX_ERROR. The count resets on every 0 and on entry to RX_DATA.
- Byte pipeline:
  - Each completed byte enters a pending register.
  - The pending byte moves to the output register when the next byte completes (last=0) or when SE0 is seen (last=1).
  - Reaching SE0 with a bit count that is nonzero mod 8 is a frame error; the partial byte is discarded.
- PID: byte 0. rxPIDError = (pid[7:4] != ~pid[3:0]).
- CRC select from pid[1:0]:
  - 2'b11: CRC16, good residual 16'h800D.
  - 2'b01: CRC5, good residual 5'h0C.
  - otherwise: none, and rxCRCError = 0.
  - CRC runs over unstuffed bits after the PID, including the CRC field.
- Overflow: if the pending byte must be promoted while rxDataValid=1 and no transfer happens that cycle, set rxFrameError and drop the new byte. The output byte is never overwritten.
- Reset: all outputs 0, rxData = 8'h00, state RX_WAIT_SYNC, pipeline cleared. Reset mid-packet discards everything.

## Timing
- rxDataValid rises one cycle after the 8th unstuffed bit of byte n+1 is sampled. For the last byte, it rises one cycle after the first SE0 sample.
- rxData and all flags are held stable while rxDataValid=1 and rxAcceptNewData=0.
- On a transfer with no new promotion, rxDataValid falls the next cycle.
- A transfer and a promotion in the same cycle both succeed: the output is reloaded, with no bubble.
- receiving rises in the cycle RX_DATA is entered and falls in the cycle RX_WAIT_SYNC is re-entered.
- Error flags update together with the rxDataValid assertion of the byte they qualify. rxFrameError updates in the cycle the error is detected.
- Stuffed-bit drop adds no latency: the bit is simply not counted.

## Configuration
- USB_RX_CRC_CHECK_EN defined: CRC5/CRC16 checking as above.
- Not defined: no CRC logic is built and rxCRCError is tied to 0. Bytes are still delivered, including the CRC bytes.

## Structure
- sie_defs_pkg holds:
  - the RxStates enum
  - line-state constants (J, K, SE0)
  - SYNC_DECODED = 8'h80
  - CRC16_RESIDUAL = 16'h800D and CRC5_RESIDUAL = 5'h0C
  - the existing PID_Types
- Sub-module nrzi_decoder (clk12, RST, line sample in, decoded bit out, SE0 flag out), the inverse of nrzi_encoder.
- CRC reuses usb_crc, with validCRC consumed.

## Test plan
- ACK: SYNC, PID 0xD2, EOP -> one byte 0xD2 with last=1, PIDErr=0, CRCErr=0, FrameErr=0.
- DATA0: PID 0xC3, payload 0x01 0x02, correct CRC16 from a reference model -> 5 bytes in order, last only on the 5th, CRCErr=0. Flip one payload bit -> CRCErr=1.
- Stuffing: payload 0xFF 0xFF with stuffed zeros -> bytes 0xFF 0xFF delivered. Seven consecutive 1s -> rxFrameError=1, no last byte, and the next valid packet is received cleanly.
- Backpressure: rxAcceptNewData=0 for 20 bytes-worth -> first byte held, then rxFrameError=1 on the next promotion; the held byte stays unchanged.
- Boundary: SE0 after 12 data bits -> rxFrameError=1, no last byte. PID 0xD3 -> rxPIDError=1.
- RST asserted mid-DATA0 -> all outputs 0 on the next cycle; a following ACK packet is received correctly.
